// File: rtl/mac_int_fsm_param.sv
// Signed multiply-accumulate with a four-state sequencer.
// Saturating or truncating result, sticky overflow, saturating product counter.
module mac_int_fsm_param #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  output logic                     ready,
  output logic signed [OUT_W-1:0]  y,
  output logic                     done,
  output logic                     overflow,
  output logic [CNT_W-1:0]         count
);

  localparam int P_W = 2 * DATA_W;

  // Bounds of the OUT_W signed range, widened to accumulator width
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  a_q, a_d;
  logic signed [DATA_W-1:0]  b_q, b_d;
  logic                      clr_q, clr_d;
  logic signed [P_W-1:0]     prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [OUT_W-1:0]   y_q, y_d;
  logic                      ovf_q, ovf_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_sum;
  logic                      hi_oor;
  logic                      lo_oor;
  logic signed [OUT_W-1:0]   y_fit;

  always_comb begin
    acc_base = clr_q ? '0 : acc_q;
    acc_sum  = acc_base + ACC_W'(prod_q);
    hi_oor   = acc_sum > Y_MAX;
    lo_oor   = acc_sum < Y_MIN;
    y_fit    = acc_sum[OUT_W-1:0];
    if (SAT_EN != 0) begin
      if (hi_oor) y_fit = Y_MAX[OUT_W-1:0];
      else if (lo_oor) y_fit = Y_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    clr_d   = clr_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          a_d     = A;
          b_d     = B;
          clr_d   = clear;
          state_d = MUL;
        end else if (clear) begin
          acc_d = '0;
          y_d   = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
      end
      MUL: begin
        prod_d  = P_W'(a_q) * P_W'(b_q);
        state_d = ACC;
      end
      ACC: begin
        acc_d = acc_sum;
        y_d   = y_fit;
        ovf_d = (ovf_q & ~clr_q) | hi_oor | lo_oor;
        if (clr_q) cnt_d = CNT_W'(1);
        else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      clr_q   <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      clr_q   <= clr_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready    = state_q == IDLE;
  assign done     = state_q == DONE;
  assign y        = y_q;
  assign overflow = ovf_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_mac_int_fsm_param.sv
// Bench for mac_int_fsm_param: default, truncating and 2-bit-counter builds
// driven in lockstep and checked against an integer accumulator model.
module tb_mac_int_fsm_param;

  logic clk = 1'b0;
  logic rst_n;
  logic valid;
  logic clear;
  logic signed [15:0] A;
  logic signed [15:0] B;

  logic ready0, ready1, ready2;
  logic done0, done1, done2;
  logic ovf0, ovf1, ovf2;
  logic signed [31:0] y0, y1, y2;
  logic [7:0] count0, count1;
  logic [1:0] count2;

  int n_checks = 0;
  int n_fail = 0;

  longint acc_m;
  bit ovf_m;
  int cnt_m;

  always #5 clk = ~clk;

  mac_int_fsm_param u_def (
    .clk(clk), .reset(rst_n), .valid(valid), .clear(clear),
    .A(A), .B(B), .ready(ready0), .y(y0), .done(done0),
    .overflow(ovf0), .count(count0)
  );

  mac_int_fsm_param #(.SAT_EN(0)) u_trunc (
    .clk(clk), .reset(rst_n), .valid(valid), .clear(clear),
    .A(A), .B(B), .ready(ready1), .y(y1), .done(done1),
    .overflow(ovf1), .count(count1)
  );

  mac_int_fsm_param #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .reset(rst_n), .valid(valid), .clear(clear),
    .A(A), .B(B), .ready(ready2), .y(y2), .done(done2),
    .overflow(ovf2), .count(count2)
  );

  function automatic logic signed [31:0] exp_sat();
    if (acc_m > 64'sd2147483647) return 32'sh7fffffff;
    if (acc_m < -64'sd2147483648) return 32'sh80000000;
    return acc_m[31:0];
  endfunction

  function automatic logic signed [31:0] exp_trunc();
    return acc_m[31:0];
  endfunction

  function automatic int exp_cnt(input int lim);
    return (cnt_m > lim) ? lim : cnt_m;
  endfunction

  task automatic model_pair(input int a, input int b, input bit clr);
    longint s;
    logic signed [39:0] w;
    s = (clr ? 64'sd0 : acc_m) + longint'(a) * longint'(b);
    w = s[39:0];
    acc_m = w;
    ovf_m = (clr ? 1'b0 : ovf_m)
          | (acc_m > 64'sd2147483647)
          | (acc_m < -64'sd2147483648);
    cnt_m = clr ? 1 : cnt_m + 1;
  endtask

  task automatic model_zero();
    acc_m = 0;
    ovf_m = 0;
    cnt_m = 0;
  endtask

  // Starts and ends on a falling edge with all builds in IDLE
  task automatic run_pair(input int a, input int b, input bit clr);
    logic signed [31:0] es, et;
    n_checks++;
    if (ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL pair_ready: got %b want 1", ready0);
    end
    valid = 1'b1;
    A = 16'(a);
    B = 16'(b);
    clear = clr;
    model_pair(a, b, clr);
    es = exp_sat();
    et = exp_trunc();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      valid = 1'($urandom);
      clear = 1'($urandom);
      A = 16'($urandom);
      B = 16'($urandom);
      n_checks++;
      if ({ready0, done0, done1, done2} !== 4'b0000) begin
        n_fail++;
        $display("FAIL busy_flags k=%0d: got %b want 0000",
                 k, {ready0, done0, done1, done2});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({done0, done1, done2} !== 3'b111) begin
      n_fail++;
      $display("FAIL done_pulse: got %b want 111", {done0, done1, done2});
    end
    n_checks++;
    if (y0 !== es || y2 !== es) begin
      n_fail++;
      $display("FAIL y_sat: got %0d/%0d want %0d", y0, y2, es);
    end
    n_checks++;
    if (y1 !== et) begin
      n_fail++;
      $display("FAIL y_trunc: got %0d want %0d", y1, et);
    end
    n_checks++;
    if (count0 !== 8'(exp_cnt(255)) || count1 !== 8'(exp_cnt(255))) begin
      n_fail++;
      $display("FAIL count8: got %0d/%0d want %0d",
               count0, count1, exp_cnt(255));
    end
    n_checks++;
    if (count2 !== 2'(exp_cnt(3))) begin
      n_fail++;
      $display("FAIL count2: got %0d want %0d", count2, exp_cnt(3));
    end
    n_checks++;
    if ({ovf0, ovf1, ovf2} !== {3{ovf_m}}) begin
      n_fail++;
      $display("FAIL overflow: got %b want %b",
               {ovf0, ovf1, ovf2}, {3{ovf_m}});
    end
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
    n_checks++;
    if (done0 !== 1'b0 || ready0 !== 1'b1 || y0 !== es) begin
      n_fail++;
      $display("FAIL after_done: got d=%b r=%b y=%0d want 0 1 %0d",
               done0, ready0, y0, es);
    end
  endtask

  task automatic clear_idle();
    valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
    n_checks++;
    if ({y0, y1, y2} !== 96'd0 || {count0, count1, count2} !== 18'd0
        || {ovf0, ovf1, ovf2} !== 3'b000) begin
      n_fail++;
      $display("FAIL clear_idle: got y=%0d c=%0d o=%b want 0 0 0",
               y0, count0, {ovf0, ovf1, ovf2});
    end
    n_checks++;
    if ({done0, done1, done2} !== 3'b000 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_idle_state: got d=%b r=%b want 000 1",
               {done0, done1, done2}, ready0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b1;
    clear = 1'b0;
    A = 16'sd5;
    B = 16'sd5;
    model_zero();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({y0, y1, y2} !== 96'd0 || {count0, count1, count2} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got y=%0d c=%0d want 0 0", y0, count0);
    end
    n_checks++;
    if ({ready0, ready1, ready2} !== 3'b111
        || {done0, done1, done2, ovf0, ovf1, ovf2} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got r=%b d=%b o=%b want 111 000 000",
               {ready0, ready1, ready2}, {done0, done1, done2},
               {ovf0, ovf1, ovf2});
    end
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_accumulate();
    int pa[7] = '{30, 10, 50, 100, 100, 100, 11};
    int pb[7] = '{40, 16, 25, 23, 24, -2, -11};
    int py[7] = '{1200, 1360, 2610, 4910, 7310, 7110, 6989};
    for (int i = 0; i < 7; i++) begin
      run_pair(pa[i], pb[i], 1'b0);
      n_checks++;
      if (y0 !== py[i]) begin
        n_fail++;
        $display("FAIL acc_seq[%0d]: got %0d want %0d", i, y0, py[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (count0 !== 8'd5 || ovf0 !== 1'b0) begin
          n_fail++;
          $display("FAIL acc_five: got c=%0d o=%b want 5 0", count0, ovf0);
        end
      end
    end
    run_pair(40, -50, 1'b1);
    n_checks++;
    if (y0 !== -32'sd2000 || count0 !== 8'd1) begin
      n_fail++;
      $display("FAIL clear_accept: got y=%0d c=%0d want -2000 1",
               y0, count0);
    end
  endtask

  task automatic test_saturation();
    clear_idle();
    run_pair(-32768, -32768, 1'b0);
    n_checks++;
    if (y0 !== 32'sd1073741824 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_first: got y=%0d o=%b want 1073741824 0", y0, ovf0);
    end
    run_pair(-32768, -32768, 1'b0);
    n_checks++;
    if (y0 !== 32'sh7fffffff || ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_second: got y=%0d o=%b want 2147483647 1", y0, ovf0);
    end
    n_checks++;
    if (y1 !== 32'sh80000000 || ovf1 !== 1'b1) begin
      n_fail++;
      $display("FAIL trunc_second: got y=%0d o=%b want -2147483648 1",
               y1, ovf1);
    end
    run_pair(3, 3, 1'b0);
    n_checks++;
    if (ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", ovf0);
    end
  endtask

  task automatic test_valid_hold();
    int dones = 0;
    logic signed [31:0] es;
    valid = 1'b1;
    clear = 1'b0;
    A = 16'sd12;
    B = -16'sd7;
    model_pair(12, -7, 1'b0);
    es = exp_sat();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) dones++;
      n_checks++;
      if (ready0 !== (k == 4) || done0 !== (k == 3)) begin
        n_fail++;
        $display("FAIL hold_k%0d: got r=%b d=%b want %b %b",
                 k, ready0, done0, k == 4, k == 3);
      end
    end
    valid = 1'b0;
    n_checks++;
    if (dones != 1 || y0 !== es) begin
      n_fail++;
      $display("FAIL hold_result: got dones=%0d y=%0d want 1 %0d",
               dones, y0, es);
    end
    @(negedge clk);
    n_checks++;
    if (done0 !== 1'b0 || count0 !== 8'(exp_cnt(255))) begin
      n_fail++;
      $display("FAIL hold_single: got d=%b c=%0d want 0 %0d",
               done0, count0, exp_cnt(255));
    end
  endtask

  task automatic test_async_reset();
    int dones = 0;
    valid = 1'b1;
    clear = 1'b0;
    A = 16'sd9;
    B = 16'sd9;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_zero();
    n_checks++;
    if ({y0, count0, ovf0, done0} !== 42'd0 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got y=%0d c=%0d o=%b d=%b r=%b want 0",
               y0, count0, ovf0, done0, ready0);
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL async_no_done: got %0d want 0", dones);
    end
    run_pair(7, 2, 1'b0);
    n_checks++;
    if (y0 !== 32'sd14 || count0 !== 8'd1) begin
      n_fail++;
      $display("FAIL post_reset_pair: got y=%0d c=%0d want 14 1", y0, count0);
    end
  endtask

  task automatic test_count_sat();
    clear_idle();
    for (int i = 0; i < 5; i++) run_pair(i + 1, 2, 1'b0);
    n_checks++;
    if (count2 !== 2'd3 || count0 !== 8'd5) begin
      n_fail++;
      $display("FAIL count_stick: got %0d/%0d want 3 5", count2, count0);
    end
    clear_idle();
  endtask

  task automatic test_random();
    logic signed [15:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(3) == 0) begin
        ra = ($urandom_range(1) == 0) ? 16'sh8000 : 16'sh7fff;
        rb = ra;
      end
      if ($urandom_range(15) == 0) clear_idle();
      run_pair(int'(ra), int'(rb), $urandom_range(7) == 0);
    end
  endtask

  initial begin
    valid = 1'b0;
    clear = 1'b0;
    A = '0;
    B = '0;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_accumulate();
    test_saturation();
    test_valid_hold();
    test_async_reset();
    test_count_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
